regfile_stream_reader: RTL and testbench

//  Read-side sequencer for the register_file block in the Xnorator datapath.
//  On start, walks a contiguous, wrapping address range through one async read port.

---
 rtl/regfile_stream_reader.sv | 136 +++++++++++++
 tb/tb_regfile_stream_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_stream_reader.sv
// Burst read sequencer: walks a wrapping address range through an async regfile
// read port and presents each word as a registered valid/ready stream beat.
module regfile_stream_reader #(
  parameter int DataSize  = 32,
  parameter int DataWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [$clog2(DataSize)-1:0]   base_addr_i,
  input  logic [$clog2(DataSize):0]     len_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(DataSize)-1:0]   raddr_o,
  input  logic [DataWidth-1:0]          rdata_i,
  output logic [DataWidth-1:0]          out_data_o,
  output logic                          out_valid_o,
  output logic                          out_last_o,
  input  logic                          out_ready_i
);

  localparam int AddrWidth = $clog2(DataSize);
  localparam logic [AddrWidth-1:0] AddrOne = AddrWidth'(1);
  localparam logic [AddrWidth:0]   RemOne  = (AddrWidth + 1)'(1);
  localparam logic [AddrWidth:0]   RemZero = (AddrWidth + 1)'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  state_e                r_state;
  logic [AddrWidth-1:0]  r_addr;
  logic [AddrWidth:0]    r_rem;
  logic [DataWidth-1:0]  r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_done;

  state_e                w_state_nxt;
  logic [AddrWidth-1:0]  w_addr_nxt;
  logic [AddrWidth:0]    w_rem_nxt;
  logic [DataWidth-1:0]  w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_last_nxt;
  logic                  w_done_nxt;
  logic                  w_load;

  // Next-state and datapath update; the output slot refills whenever it is empty or draining.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      IDLE: begin
        if (start_i && (len_i != RemZero)) begin
          w_state_nxt = RUN;
          w_addr_nxt  = base_addr_i;
          w_rem_nxt   = len_i;
        end else if (start_i) begin
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      RUN: begin
        w_load = !r_valid || out_ready_i;
        if (w_load) begin
          w_data_nxt  = rdata_i;
          w_valid_nxt = 1'b1;
          w_last_nxt  = (r_rem == RemOne);
          w_addr_nxt  = r_addr + AddrOne;
          w_rem_nxt   = r_rem - RemOne;
          // Final word captured: wait in LAST for its handshake, fetch nothing more.
          w_state_nxt = (r_rem == RemOne) ? LAST : RUN;
        end else begin
          w_state_nxt = RUN;
        end
      end

      LAST: begin
        if (r_valid && out_ready_i) begin
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = LAST;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= {AddrWidth{1'b0}};
      r_rem   <= RemZero;
      r_data  <= {DataWidth{1'b0}};
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign raddr_o     = r_addr;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign out_data_o  = r_data;
  assign out_valid_o = r_valid;
  assign out_last_o  = r_last;

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Directed bench for regfile_stream_reader with a bench-owned register file model.
module tb_regfile_stream_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [4:0]  base_addr_i;
  logic [5:0]  len_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  raddr_o;
  logic [31:0] rdata_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_last_o;
  logic        out_ready_i;

  logic [31:0] mem [32];
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_stream_reader #(.DataSize(32), .DataWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .raddr_o(raddr_o),
    .rdata_i(rdata_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_last_o(out_last_o), .out_ready_i(out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Register file: registered write, combinational read.
  always @(posedge clk_i) if (we) mem[waddr] <= wdata;
  assign rdata_i = mem[raddr_o];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic [4:0]  base;
    logic [5:0]  len;
    logic        e_busy;
    logic        e_done;
    logic        e_valid;
    logic        e_last;
    logic [4:0]  e_raddr;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [4:0] b, input logic [5:0] l,
                              input logic eb, input logic ed, input logic ev, input logic el,
                              input logic [4:0] ea, input logic [31:0] edat);
    vec_t v;
    v.start = s; v.base = b; v.len = l;
    v.e_busy = eb; v.e_done = ed; v.e_valid = ev; v.e_last = el;
    v.e_raddr = ea; v.e_data = edat;
    return v;
  endfunction

  // Multi-cycle burst with a cyclic ready pattern; mem[i] == i is assumed.
  task automatic burst(input logic [4:0] base, input logic [5:0] len, input logic [7:0] rpat,
                       input int plen, input bit mid_start);
    int n;
    bit fin, hs, hl, stalled;
    logic [31:0] hd, held;
    logic [4:0] exp_addr;
    n = 0; fin = 1'b0;
    start_i = 1'b1; base_addr_i = base; len_i = len; out_ready_i = rpat[0];
    tick();
    start_i = 1'b0;
    check("burst_busy_on", {31'd0, busy_o}, 32'd1);
    check("burst_raddr_base", {27'd0, raddr_o}, {27'd0, base});
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      out_ready_i = rpat[cyc % plen];
      start_i = mid_start && (cyc == 2 || cyc == 4);
      base_addr_i = 5'd17; len_i = 6'd2;
      hs = out_valid_o & out_ready_i; hd = out_data_o; hl = out_last_o;
      stalled = out_valid_o & ~out_ready_i; held = out_data_o;
      tick();
      if (hs) begin
        exp_addr = base + n[4:0];
        check("beat_data", hd, {27'd0, exp_addr});
        check("beat_last", {31'd0, hl}, {31'd0, (n == int'(len) - 1)});
        n++;
        if (hl) begin
          fin = 1'b1;
          check("burst_done", {31'd0, done_o}, 32'd1);
          check("burst_busy_off", {31'd0, busy_o}, 32'd0);
        end
      end else begin
        check("no_early_done", {31'd0, done_o}, 32'd0);
      end
      if (stalled) begin
        check("stall_valid", {31'd0, out_valid_o}, 32'd1);
        check("stall_data", out_data_o, held);
      end
    end
    start_i = 1'b0;
    check("burst_done_in_budget", {31'd0, fin}, 32'd1);
    check("beat_count", n, int'(len));
    tick();
    check("done_single", {31'd0, done_o}, 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i;
    we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    start_i = 1'b0; base_addr_i = 5'd0; len_i = 6'd0; out_ready_i = 1'b1;
    rst_ni = 1'b0;

    //            st  base    len    busy done vld  last raddr  data
    vecs[0]  = mk(1, 5'd3,  6'd4, 1, 0, 0, 0, 5'd3,  32'd0);
    vecs[1]  = mk(0, 5'd0,  6'd0, 1, 0, 1, 0, 5'd4,  32'd3);
    vecs[2]  = mk(0, 5'd0,  6'd0, 1, 0, 1, 0, 5'd5,  32'd4);
    vecs[3]  = mk(0, 5'd0,  6'd0, 1, 0, 1, 0, 5'd6,  32'd5);
    vecs[4]  = mk(0, 5'd0,  6'd0, 1, 0, 1, 1, 5'd7,  32'd6);
    vecs[5]  = mk(0, 5'd0,  6'd0, 0, 1, 0, 0, 5'd7,  32'd6);
    vecs[6]  = mk(0, 5'd0,  6'd0, 0, 0, 0, 0, 5'd7,  32'd6);
    vecs[7]  = mk(1, 5'd30, 6'd4, 1, 0, 0, 0, 5'd30, 32'd6);
    vecs[8]  = mk(0, 5'd0,  6'd0, 1, 0, 1, 0, 5'd31, 32'd30);
    vecs[9]  = mk(0, 5'd0,  6'd0, 1, 0, 1, 0, 5'd0,  32'd31);
    vecs[10] = mk(0, 5'd0,  6'd0, 1, 0, 1, 0, 5'd1,  32'd0);
    vecs[11] = mk(0, 5'd0,  6'd0, 1, 0, 1, 1, 5'd2,  32'd1);
    vecs[12] = mk(0, 5'd0,  6'd0, 0, 1, 0, 0, 5'd2,  32'd1);
    vecs[13] = mk(1, 5'd9,  6'd0, 0, 1, 0, 0, 5'd2,  32'd1);
    vecs[14] = mk(0, 5'd0,  6'd0, 0, 0, 0, 0, 5'd2,  32'd1);

    #12;
    check("rst_busy",  {31'd0, busy_o}, 32'd0);
    check("rst_done",  {31'd0, done_o}, 32'd0);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_last",  {31'd0, out_last_o}, 32'd0);
    check("rst_data",  out_data_o, 32'd0);
    check("rst_raddr", {27'd0, raddr_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Bursts 3..6 and 30..1 back to back, then len 0 started in the done cycle.
    for (int i = 0; i < 15; i++) begin
      start_i = vecs[i].start; base_addr_i = vecs[i].base; len_i = vecs[i].len;
      out_ready_i = 1'b1;
      tick();
      check($sformatf("v%0d_busy", i),  {31'd0, busy_o},      {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d_done", i),  {31'd0, done_o},      {31'd0, vecs[i].e_done});
      check($sformatf("v%0d_valid", i), {31'd0, out_valid_o}, {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d_last", i),  {31'd0, out_last_o},  {31'd0, vecs[i].e_last});
      check($sformatf("v%0d_raddr", i), {27'd0, raddr_o},     {27'd0, vecs[i].e_raddr});
      check($sformatf("v%0d_data", i),  out_data_o,           vecs[i].e_data);
    end
    start_i = 1'b0;

    burst(5'd0, 6'd5, 8'b1101_1001, 8, 1'b0);
    burst(5'd8, 6'd6, 8'hFF, 1, 1'b1);
    burst(5'd5, 6'd32, 8'hFF, 1, 1'b0);
    burst(5'd31, 6'd34, 8'b0000_0101, 3, 1'b0);

    // Reset mid-burst: outputs clear at once and no done pulse follows.
    start_i = 1'b1; base_addr_i = 5'd10; len_i = 6'd6; out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_valid", {31'd0, out_valid_o}, 32'd1);
    check("pre_rst_data", out_data_o, 32'd12);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy_o}, 32'd0);
    check("mid_rst_last",  {31'd0, out_last_o}, 32'd0);
    check("mid_rst_data",  out_data_o, 32'd0);
    check("mid_rst_raddr", {27'd0, raddr_o}, 32'd0);
    tick();
    check("mid_rst_done", {31'd0, done_o}, 32'd0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_done", {31'd0, done_o}, 32'd0);
    check("post_rst_busy", {31'd0, busy_o}, 32'd0);

    // Write to address 5 on the edge that captures it: old word streams, new word next burst.
    start_i = 1'b1; base_addr_i = 5'd3; len_i = 6'd4; out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("wr_beat3", out_data_o, 32'd3);
    tick();
    check("wr_beat4", out_data_o, 32'd4);
    check("wr_raddr5", {27'd0, raddr_o}, 32'd5);
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000_00AA;
    tick();
    we = 1'b0;
    check("wr_beat5_old", out_data_o, 32'd5);
    tick();
    check("wr_beat6", out_data_o, 32'd6);
    check("wr_last", {31'd0, out_last_o}, 32'd1);
    tick();
    check("wr_done", {31'd0, done_o}, 32'd1);
    start_i = 1'b1; base_addr_i = 5'd5; len_i = 6'd1;
    tick();
    start_i = 1'b0;
    tick();
    check("wr_new_valid", {31'd0, out_valid_o}, 32'd1);
    check("wr_new_data", out_data_o, 32'h0000_00AA);
    check("wr_new_last", {31'd0, out_last_o}, 32'd1);
    tick();
    check("wr_new_done", {31'd0, done_o}, 32'd1);
    check("wr_new_valid_off", {31'd0, out_valid_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
